// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: coprocessor op codes, register addresses, field positions.
package cp0_pkg;

  typedef enum logic [1:0] {
    EXE_CP_NONE  = 2'd0,
    EXE_CP_STORE = 2'd1,
    EXE_CP0_ERET = 2'd2
  } cp_oper_e;

  typedef enum logic {
    CP0_IDLE,
    CP0_IN_SVC
  } cp0_state_e;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPCR    = 5'd14;
  localparam logic [4:0] CP0_EHBR    = 5'd15;

  localparam int unsigned ST_IE  = 0;
  localparam int unsigned ST_EXL = 1;
  localparam int unsigned ST_IM  = 8;
  localparam int unsigned CA_EXC = 2;
  localparam int unsigned CA_IP  = 8;

endpackage

// File: rtl/cp0_irq_prio.sv
// Fixed-priority encoder: lowest set request index wins.
module cp0_irq_prio #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [2:0]   id_o
);

  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    // Scan downward so the lowest requesting index is the last one assigned.
    for (int unsigned i = N; i > 0; i--) begin
      if (req_i[i-1]) begin
        valid_o = 1'b1;
        id_o    = 3'(i - 1);
      end
    end
  end

endmodule

// File: rtl/cp0_vec_irq.sv
// CP0 with edge-latched, masked, fixed-priority vectored interrupts and EXL nesting guard.
// Define CP0_TIMER_EN to add COUNT/COMPARE and a timer interrupt line at index NUM_IRQ.
module cp0_vec_irq
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_IRQ   = 8,
  parameter int unsigned VEC_SHIFT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         oper,
  input  logic [4:0]         addr_r,
  output logic [31:0]        data_r,
  input  logic [4:0]         addr_w,
  input  logic [31:0]        data_w,
  input  logic               ir_en,
  input  logic [NUM_IRQ-1:0] ir_in,
  input  logic [31:0]        ret_addr,
  output logic               jump_en,
  output logic [31:0]        jump_addr,
  output logic [2:0]         ir_id
);

`ifdef CP0_TIMER_EN
  localparam int unsigned NL = NUM_IRQ + 1;
`else
  localparam int unsigned NL = NUM_IRQ;
`endif

  cp0_state_e         state_q, state_d;
  logic               ie_q, ie_d;
  logic [NL-1:0]      im_q, im_d;
  logic [NL-1:0]      ip_q, ip_d;
  logic [2:0]         exc_q, exc_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        ehbr_q, ehbr_d;
  logic [NUM_IRQ-1:0] irq_q, irq_d;
`ifdef CP0_TIMER_EN
  logic [31:0]        count_q, count_d;
  logic [31:0]        cmp_q, cmp_d;
  logic               tvalid_q, tvalid_d;
`endif

  logic        pend_valid;
  logic [2:0]  pend_id;
  logic        is_store, is_eret, take;
  logic [31:0] status_rd, cause_rd;

  cp0_irq_prio #(.N(NL)) u_prio (
    .req_i   (ip_q & im_q),
    .valid_o (pend_valid),
    .id_o    (pend_id)
  );

  assign is_store = (oper == EXE_CP_STORE);
  assign is_eret  = (oper == EXE_CP0_ERET);
  assign take     = ir_en && ie_q && (state_q == CP0_IDLE) && pend_valid && !is_eret;

  always_comb begin
    state_d = state_q;
    ie_d    = ie_q;
    im_d    = im_q;
    ip_d    = ip_q;
    exc_d   = exc_q;
    epc_d   = epc_q;
    ehbr_d  = ehbr_q;
    irq_d   = ir_in;
`ifdef CP0_TIMER_EN
    count_d  = count_q + 32'd1;
    cmp_d    = cmp_q;
    tvalid_d = 1'b1;
`endif
    jump_en   = 1'b0;
    jump_addr = '0;
    ir_id     = '0;

    if (take) begin
      jump_en   = 1'b1;
      jump_addr = ehbr_q + (32'(pend_id) << VEC_SHIFT);
      ir_id     = pend_id;
    end else if (is_eret) begin
      jump_en   = 1'b1;
      jump_addr = epc_q;
    end

    if (is_store) begin
      case (addr_w)
        CP0_STATUS: begin
          ie_d    = data_w[ST_IE];
          state_d = data_w[ST_EXL] ? CP0_IN_SVC : CP0_IDLE;
          im_d    = data_w[ST_IM +: NL];
        end
        CP0_CAUSE: ip_d   = data_w[CA_IP +: NL];
        CP0_EPCR:  epc_d  = data_w;
        CP0_EHBR:  ehbr_d = data_w;
`ifdef CP0_TIMER_EN
        CP0_COUNT:   count_d = data_w;
        CP0_COMPARE: cmp_d   = data_w;
`endif
        default: ;
      endcase
    end

    // Take updates are applied after the MTC0 write so they win on shared fields.
    if (take) begin
      epc_d   = ret_addr;
      state_d = CP0_IN_SVC;
      exc_d   = pend_id;
      for (int unsigned i = 0; i < NL; i++) begin
        if (pend_id == 3'(i)) ip_d[i] = 1'b0;
      end
    end else if (is_eret) begin
      state_d = CP0_IDLE;
    end

    ip_d[NUM_IRQ-1:0] = ip_d[NUM_IRQ-1:0] | (ir_in & ~irq_q);
`ifdef CP0_TIMER_EN
    if (tvalid_q && (count_q == cmp_q)) ip_d[NUM_IRQ] = 1'b1;
    if (is_store && (addr_w == CP0_COMPARE)) ip_d[NUM_IRQ] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CP0_IDLE;
      ie_q     <= 1'b0;
      im_q     <= '0;
      ip_q     <= '0;
      exc_q    <= '0;
      epc_q    <= '0;
      ehbr_q   <= '0;
      irq_q    <= '0;
`ifdef CP0_TIMER_EN
      count_q  <= '0;
      cmp_q    <= '0;
      tvalid_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ie_q     <= ie_d;
      im_q     <= im_d;
      ip_q     <= ip_d;
      exc_q    <= exc_d;
      epc_q    <= epc_d;
      ehbr_q   <= ehbr_d;
      irq_q    <= irq_d;
`ifdef CP0_TIMER_EN
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      tvalid_q <= tvalid_d;
`endif
    end
  end

  always_comb begin
    status_rd              = '0;
    status_rd[ST_IE]       = ie_q;
    status_rd[ST_EXL]      = (state_q == CP0_IN_SVC);
    status_rd[ST_IM +: NL] = im_q;
    cause_rd               = '0;
    cause_rd[CA_IP +: NL]  = ip_q;
    cause_rd[CA_EXC +: 5]  = {2'b00, exc_q};
  end

  always_comb begin
    case (addr_r)
      CP0_STATUS:  data_r = status_rd;
      CP0_CAUSE:   data_r = cause_rd;
      CP0_EPCR:    data_r = epc_q;
      CP0_EHBR:    data_r = ehbr_q;
`ifdef CP0_TIMER_EN
      CP0_COUNT:   data_r = count_q;
      CP0_COMPARE: data_r = cmp_q;
`endif
      default:     data_r = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_vec_irq.sv
// Self-checking bench for cp0_vec_irq: directed scenarios plus randomized traffic vs a behavioural model.
module tb_cp0_vec_irq;

`ifdef CP0_TIMER_EN
  localparam int NI = 7;
`else
  localparam int NI = 8;
`endif
  localparam int NL = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    oper;
  logic [4:0]    addr_r;
  logic [31:0]   data_r;
  logic [4:0]    addr_w;
  logic [31:0]   data_w;
  logic          ir_en;
  logic [NI-1:0] ir_in;
  logic [31:0]   ret_addr;
  logic          jump_en;
  logic [31:0]   jump_addr;
  logic [2:0]    ir_id;

  int n_checks = 0;
  int n_fail   = 0;

  cp0_vec_irq #(.NUM_IRQ(NI), .VEC_SHIFT(5)) dut (
    .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r),
    .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .ir_in(ir_in),
    .ret_addr(ret_addr), .jump_en(jump_en), .jump_addr(jump_addr), .ir_id(ir_id)
  );

  always #5 clk = ~clk;

  // Behavioural model of the architectural state
  bit          m_ie, m_exl, m_tvalid;
  bit [NL-1:0] m_im, m_ip;
  bit [NI-1:0] m_prev;
  bit [31:0]   m_epc, m_ehbr, m_count, m_cmp;
  bit [2:0]    m_exc;
  bit          e_take, e_jen;
  bit [31:0]   e_jaddr;
  bit [2:0]    e_id;

  task automatic predict();
    bit found;
    found = 0; e_take = 0; e_id = 0; e_jen = 0; e_jaddr = 0;
    if (m_ie && !m_exl && ir_en && oper != 2'd2)
      for (int i = 0; i < NL; i++)
        if (!found && m_ip[i] && m_im[i]) begin found = 1; e_take = 1; e_id = 3'(i); end
    if (e_take) begin e_jen = 1; e_jaddr = m_ehbr + 32'(e_id) * 32; end
    else if (oper == 2'd2) begin e_jen = 1; e_jaddr = m_epc; end
  endtask

  function automatic bit [31:0] m_read(input bit [4:0] a);
    bit [31:0] v;
    v = '0;
    case (a)
      5'd12: begin v[0] = m_ie; v[1] = m_exl; v[8 +: NL] = m_im; end
      5'd13: begin v[8 +: NL] = m_ip; v[6:2] = {2'b00, m_exc}; end
      5'd14: v = m_epc;
      5'd15: v = m_ehbr;
`ifdef CP0_TIMER_EN
      5'd9:  v = m_count;
      5'd11: v = m_cmp;
`endif
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_update();
    bit [NL-1:0] nip;
    bit [31:0]   ncount;
    bit          match;
    if (rst) begin
      m_ie = 0; m_exl = 0; m_im = 0; m_ip = 0; m_prev = 0; m_exc = 0;
      m_epc = 0; m_ehbr = 0; m_count = 0; m_cmp = 0; m_tvalid = 0;
      return;
    end
    nip    = m_ip;
    ncount = m_count + 1;
    match  = m_tvalid && (m_count == m_cmp);
    if (oper == 2'd1) begin
      case (addr_w)
        5'd12: begin m_ie = data_w[0]; m_exl = data_w[1]; m_im = data_w[8 +: NL]; end
        5'd13: nip = data_w[8 +: NL];
        5'd14: m_epc = data_w;
        5'd15: m_ehbr = data_w;
`ifdef CP0_TIMER_EN
        5'd9:  ncount = data_w;
        5'd11: m_cmp = data_w;
`endif
        default: ;
      endcase
    end
    if (e_take) begin m_epc = ret_addr; m_exl = 1; nip[e_id] = 0; m_exc = e_id; end
    else if (oper == 2'd2) m_exl = 0;
    for (int i = 0; i < NI; i++) if (ir_in[i] && !m_prev[i]) nip[i] = 1;
    m_prev = ir_in;
`ifdef CP0_TIMER_EN
    if (match) nip[NI] = 1;
    if (oper == 2'd1 && addr_w == 5'd11) nip[NI] = 0;
    m_count  = ncount;
`else
    if (match) m_count = ncount;
`endif
    m_tvalid = 1;
    m_ip = nip;
  endtask

  task automatic tick();
    predict();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input bit [4:0] a, input bit [31:0] d);
    oper = 2'd1; addr_w = a; data_w = d;
    tick();
    oper = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1; oper = 0; addr_r = 0; addr_w = 0; data_w = 0; ir_en = 0; ir_in = '0; ret_addr = 0;
    tick(); tick();
    rst = 0; #1;
    for (int a = 12; a <= 15; a++) begin
      addr_r = 5'(a); #1;
      n_checks++;
      if (data_r !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d got=%h exp=0", a, data_r); end
    end
    n_checks++;
    if (jump_en !== 1'b0 || jump_addr !== 32'h0 || ir_id !== 3'd0) begin
      n_fail++; $display("FAIL reset_jump got=%b/%h/%0d exp=0/0/0", jump_en, jump_addr, ir_id);
    end
  endtask

  task automatic test_take_vectored();
    mtc0(5'd15, 32'h100);
    mtc0(5'd12, 32'hFF01);
    ir_en = 1; ret_addr = 32'h40; ir_in = '0; ir_in[3] = 1'b1; #1;
    n_checks++;
    if (jump_en !== 1'b0) begin n_fail++; $display("FAIL edge_cycle_jen got=%b exp=0", jump_en); end
    tick();
    ir_in = '0; #1;
    n_checks++;
    if (jump_en !== 1'b1 || jump_addr !== 32'h160 || ir_id !== 3'd3) begin
      n_fail++; $display("FAIL take3 got=%b/%h/%0d exp=1/160/3", jump_en, jump_addr, ir_id);
    end
    tick();
    addr_r = 5'd14; #1;
    n_checks++;
    if (data_r !== 32'h40) begin n_fail++; $display("FAIL take3_epc got=%h exp=40", data_r); end
    addr_r = 5'd12; #1;
    n_checks++;
    if (data_r[1] !== 1'b1) begin n_fail++; $display("FAIL take3_exl got=%b exp=1", data_r[1]); end
    addr_r = 5'd13; #1;
    n_checks++;
    if (data_r[11] !== 1'b0 || data_r[6:2] !== 5'd3) begin
      n_fail++; $display("FAIL take3_cause got=%h exp=IP3 0,ExcCode 3", data_r);
    end
  endtask

  task automatic test_two_lines();
    oper = 2'd2; #1;
    n_checks++;
    if (jump_en !== 1'b1 || jump_addr !== 32'h40) begin n_fail++; $display("FAIL eret1 got=%b/%h exp=1/40", jump_en, jump_addr); end
    tick();
    oper = 2'd0; ir_in = '0; ir_in[5] = 1'b1; ir_in[2] = 1'b1;
    tick();
    ir_in = '0; #1;
    n_checks++;
    if (jump_addr !== 32'h140 || ir_id !== 3'd2) begin n_fail++; $display("FAIL take2 got=%h/%0d exp=140/2", jump_addr, ir_id); end
    tick();
    oper = 2'd2; #1;
    n_checks++;
    if (jump_addr !== 32'h40) begin n_fail++; $display("FAIL eret2 got=%h exp=40", jump_addr); end
    tick();
    oper = 2'd0; #1;
    n_checks++;
    if (jump_en !== 1'b1 || jump_addr !== 32'h1A0 || ir_id !== 3'd5) begin
      n_fail++; $display("FAIL take5 got=%b/%h/%0d exp=1/1a0/5", jump_en, jump_addr, ir_id);
    end
    tick();
    oper = 2'd2; tick(); oper = 2'd0;
  endtask

  task automatic test_nested();
    ir_in = '0; ir_in[1] = 1'b1;
    tick();
    ir_in = '0; #1;
    n_checks++;
    if (jump_addr !== 32'h120) begin n_fail++; $display("FAIL take1 got=%h exp=120", jump_addr); end
    tick();
    ir_in[0] = 1'b1;
    tick();
    ir_in = '0; addr_r = 5'd13; #1;
    n_checks++;
    if (jump_en !== 1'b0) begin n_fail++; $display("FAIL nest_block got=%b exp=0", jump_en); end
    n_checks++;
    if (data_r[8] !== 1'b1) begin n_fail++; $display("FAIL nest_ip0 got=%b exp=1", data_r[8]); end
    tick();
    oper = 2'd2; #1;
    n_checks++;
    if (jump_addr !== 32'h40) begin n_fail++; $display("FAIL nest_eret got=%h exp=40", jump_addr); end
    tick();
    oper = 2'd0; #1;
    n_checks++;
    if (jump_en !== 1'b1 || jump_addr !== 32'h100 || ir_id !== 3'd0) begin
      n_fail++; $display("FAIL nest_take0 got=%b/%h/%0d exp=1/100/0", jump_en, jump_addr, ir_id);
    end
    tick();
    oper = 2'd2; tick(); oper = 2'd0;
  endtask

  task automatic test_mask_reset();
    mtc0(5'd12, 32'hEF01);
    ir_in = '0; ir_in[4] = 1'b1;
    tick();
    ir_in = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (jump_en !== 1'b0) begin n_fail++; $display("FAIL masked_%0d got=%b exp=0", k, jump_en); end
      tick();
    end
    ir_en = 0;
    mtc0(5'd12, 32'hFF01);
    #1;
    n_checks++;
    if (jump_en !== 1'b0) begin n_fail++; $display("FAIL ir_en_off got=%b exp=0", jump_en); end
    ir_en = 1; #1;
    n_checks++;
    if (jump_addr !== 32'h180 || ir_id !== 3'd4) begin n_fail++; $display("FAIL take4 got=%h/%0d exp=180/4", jump_addr, ir_id); end
    tick();
    ir_in[2] = 1'b1;
    tick();
    ir_in = '0; rst = 1;
    tick();
    rst = 0;
    for (int a = 12; a <= 15; a++) begin
      addr_r = 5'(a); #1;
      n_checks++;
      if (data_r !== 32'h0) begin n_fail++; $display("FAIL rst_svc_reg%0d got=%h exp=0", a, data_r); end
    end
    n_checks++;
    if (jump_en !== 1'b0) begin n_fail++; $display("FAIL rst_svc_jen got=%b exp=0", jump_en); end
  endtask

  task automatic test_eret_vs_take();
    mtc0(5'd15, 32'h100);
    mtc0(5'd12, 32'hFF01);
    ir_en = 1; ret_addr = 32'h80; ir_in = '0; ir_in[5] = 1'b1;
    tick();
    ir_in = '0; tick();
    oper = 2'd2; tick(); oper = 2'd0;
    ir_en = 0; ir_in[6] = 1'b1;
    tick();
    ir_in = '0; tick();
    oper = 2'd2; ir_en = 1; #1;
    n_checks++;
    if (jump_en !== 1'b1 || jump_addr !== 32'h80) begin n_fail++; $display("FAIL eret_prio got=%b/%h exp=1/80", jump_en, jump_addr); end
    tick();
    oper = 2'd0; #1;
    n_checks++;
    if (jump_addr !== 32'h1C0 || ir_id !== 3'd6) begin n_fail++; $display("FAIL deferred_take got=%h/%0d exp=1c0/6", jump_addr, ir_id); end
    tick();
    oper = 2'd2; tick(); oper = 2'd0;
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    int waited;
    bit seen;
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd20);
    mtc0(5'd9, 32'd10);
    ir_en = 1; ir_in = '0; waited = 0; seen = 0;
    while (!seen && waited < 40) begin
      #1;
      if (jump_en === 1'b1) seen = 1;
      else begin tick(); waited++; end
    end
    n_checks++;
    if (!seen || waited != 11 || jump_addr !== 32'h1E0 || ir_id !== 3'd7) begin
      n_fail++; $display("FAIL timer_take seen=%0d wait=%0d addr=%h id=%0d exp=1/11/1e0/7", seen, waited, jump_addr, ir_id);
    end
    tick();
    oper = 2'd2; tick(); oper = 2'd0;
    mtc0(5'd12, 32'h0);
    mtc0(5'd11, m_count + 32'd3);
    repeat (4) tick();
    addr_r = 5'd13; #1;
    n_checks++;
    if (data_r[15] !== 1'b1) begin n_fail++; $display("FAIL timer_ip got=%b exp=1", data_r[15]); end
    mtc0(5'd11, 32'hFFFF0000);
    #1;
    n_checks++;
    if (data_r[15] !== 1'b0) begin n_fail++; $display("FAIL timer_clr got=%b exp=0", data_r[15]); end
  endtask
`endif

  task automatic test_random();
    bit [4:0] regs [8];
    int r;
    regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3, 5'd31};
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      r = $urandom_range(0, 15);
      oper = (r < 10) ? 2'd0 : (r < 13) ? 2'd1 : 2'd2;
      addr_w = regs[$urandom_range(0, 7)];
      data_w = $urandom;
      if (addr_w == 5'd12) begin
        data_w[7:2] = '0; data_w[31:16] = '0;
        data_w[0] = ($urandom_range(0, 3) != 0);
        data_w[1] = ($urandom_range(0, 7) == 0);
      end
      if (addr_w == 5'd15) data_w[4:0] = '0;
      ir_in = NI'($urandom);
      ir_en = ($urandom_range(0, 3) != 0);
      ret_addr = $urandom;
      addr_r = regs[$urandom_range(0, 7)];
      #1;
      predict();
      n_checks++;
      if (jump_en !== e_jen || jump_addr !== e_jaddr || ir_id !== e_id) begin
        n_fail++; $display("FAIL rnd_jump c=%0d got=%b/%h/%0d exp=%b/%h/%0d", c, jump_en, jump_addr, ir_id, e_jen, e_jaddr, e_id);
      end
      n_checks++;
      if (data_r !== m_read(addr_r)) begin
        n_fail++; $display("FAIL rnd_read c=%0d a=%0d got=%h exp=%h", c, addr_r, data_r, m_read(addr_r));
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_take_vectored();
    test_two_lines();
    test_nested();
    test_mask_reset();
    test_eret_vs_take();
`ifdef CP0_TIMER_EN
    test_timer();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
